// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : default timing constants shared by the debouncer and benches
// Revision: 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_SAMPLE_CNT_MAX = 25000;
    localparam int DEF_PULSE_CNT_MAX  = 150;
    localparam int DEF_REPEAT_TICKS   = 5000;

    // Counter width that never collapses to zero bits for tiny maxima.
    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/synchronizer.sv
// ============================================================================
// synchronizer : WIDTH-bit, STAGES-deep flop chain for off-chip inputs
// Revision: 1.0
// ============================================================================
`default_nettype none

module synchronizer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/debounce_pulse.sv
// ============================================================================
// debounce_pulse : push-button synchronizer, debouncer and press strobe.
// Optional auto-repeat enabled by defining DEBOUNCE_AUTOREPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
    parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic pulse
);

    localparam int SAMPLE_W = $clog2(SAMPLE_CNT_MAX);
    localparam int SAT_W    = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [SAT_W-1:0]    SAT_FULL    = SAT_W'(PULSE_CNT_MAX);

    if (SYNC_STAGES < 2 || SAMPLE_CNT_MAX < 2 || PULSE_CNT_MAX < 1 || REPEAT_TICKS < 1)
    begin : g_bad_params
        $error("debounce_pulse: illegal parameter value");
    end

    logic                btn_sync;
    logic [SAMPLE_W-1:0] sample_cnt;
    logic                tick;
    logic [SAT_W-1:0]    sat;
    logic                level_prev;
    logic                edge_pulse;

    synchronizer #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    // Free-running sample divider; button activity never re-phases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
        end
    end

    assign tick = (sample_cnt == SAMPLE_LAST);

    // A single low synced sample restarts qualification, ahead of any tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat <= '0;
        end else if (!btn_sync) begin
            sat <= '0;
        end else if (tick && (sat != SAT_FULL)) begin
            sat <= sat + SAT_W'(1);
        end
    end

    assign btn_level = (sat == SAT_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= btn_level;
        end
    end

    assign edge_pulse = btn_level & ~level_prev;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RPT_W = safe_clog2(REPEAT_TICKS);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             repeat_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if (!btn_level) begin
            rpt_cnt <= '0;
        end else if (tick) begin
            rpt_cnt <= (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + RPT_W'(1);
        end
    end

    // The edge pulse lands on divider phase 0, so it can never share a tick.
    assign repeat_pulse = btn_level & tick & (rpt_cnt == RPT_LAST);
    assign pulse        = edge_pulse | repeat_pulse;
`else
    assign pulse = edge_pulse;
`endif

endmodule

`default_nettype wire
